// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of the data RAM port between the
// load/store unit (M0) and a debug/DMA master (M1), with bounded hold time.
module dmem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_HOLD = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [3:0]    m0_sel,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [3:0]    m1_sel,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          ram_ren,
    output logic [3:0]    ram_wen,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic          busy
);

    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE,
        OWN0,
        OWN1
    } state_t;

    state_t        state;
    logic          last_owner;
    logic [HW-1:0] hold_cnt;
    logic          rd_valid;
    logic          rd_id;
    logic          accept;
    logic          acc_we;

    assign accept = (state == OWN0 && m0_req) || (state == OWN1 && m1_req);
    assign acc_we = (state == OWN1) ? m1_we : m0_we;

    assign m0_gnt = (state == OWN0);
    assign m1_gnt = (state == OWN1);
    assign busy   = (state != IDLE);

    // Read data is steered straight from the RAM to whichever master issued it.
    assign m0_rvalid = rd_valid && !rd_id;
    assign m1_rvalid = rd_valid && rd_id;
    assign m0_rdata  = m0_rvalid ? ram_rdata : '0;
    assign m1_rdata  = m1_rvalid ? ram_rdata : '0;

    // Issue the owner's access to the RAM port in the accept cycle.
    always_comb begin
        ram_ren   = 1'b0;
        ram_wen   = 4'b0000;
        ram_addr  = '0;
        ram_wdata = '0;
        unique case (state)
            OWN0: begin
                ram_addr  = m0_addr;
                ram_wdata = m0_wdata;
                if (m0_req) begin
                    if (m0_we) ram_wen = m0_sel;
                    else       ram_ren = 1'b1;
                end
            end
            OWN1: begin
                ram_addr  = m1_addr;
                ram_wdata = m1_wdata;
                if (m1_req) begin
                    if (m1_we) ram_wen = m1_sel;
                    else       ram_ren = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Ownership FSM with hold counter and read-return tracking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            hold_cnt   <= '0;
            rd_valid   <= 1'b0;
            rd_id      <= 1'b0;
        end else begin
            rd_valid <= accept && !acc_we;
            if (accept) rd_id <= (state == OWN1);
            unique case (state)
                IDLE: begin
                    hold_cnt <= '0;
                    if (m0_req && (!m1_req || last_owner)) begin
                        state      <= OWN0;
                        last_owner <= 1'b0;
                    end else if (m1_req) begin
                        state      <= OWN1;
                        last_owner <= 1'b1;
                    end
                end
                OWN0: begin
                    if (!m0_req) begin
                        hold_cnt <= '0;
                        if (m1_req) begin
                            state      <= OWN1;
                            last_owner <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (m1_req && hold_cnt == HOLD_LAST) begin
                        state      <= OWN1;
                        last_owner <= 1'b1;
                        hold_cnt   <= '0;
                    end else if (hold_cnt != HOLD_LAST) begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                OWN1: begin
                    if (!m1_req) begin
                        hold_cnt <= '0;
                        if (m0_req) begin
                            state      <= OWN0;
                            last_owner <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (m0_req && hold_cnt == HOLD_LAST) begin
                        state      <= OWN0;
                        last_owner <= 1'b0;
                        hold_cnt   <= '0;
                    end else if (hold_cnt != HOLD_LAST) begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scenario tasks plus randomized traffic checked
// against an ownership/memory reference model.
module tb_dmem_arbiter;

    localparam int MH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req [2];
    logic        we [2];
    logic [3:0]  sel [2];
    logic [31:0] addr [2];
    logic [31:0] wdata [2];

    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, busy;
    logic [31:0] m0_rdata, m1_rdata;
    logic        ram_ren;
    logic [3:0]  ram_wen;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;

    int checks = 0;
    int errors = 0;

    dmem_arbiter #(.AW(32), .DW(32), .MAX_HOLD(MH)) dut (
        .clk(clk), .rst(rst),
        .m0_req(req[0]), .m0_we(we[0]), .m0_sel(sel[0]),
        .m0_addr(addr[0]), .m0_wdata(wdata[0]),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(req[1]), .m1_we(we[1]), .m1_sel(sel[1]),
        .m1_addr(addr[1]), .m1_wdata(wdata[1]),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [137:0] all_outs;
    assign all_outs = {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata,
                       m1_rdata, ram_ren, ram_wen, ram_addr, ram_wdata, busy};

    function automatic logic [31:0] seed_word(input int i);
        return (32'(i) * 32'h0101_0101) ^ 32'h5A3C_96E1;
    endfunction

    // Synchronous RAM: one-cycle read latency, byte-enabled writes.
    logic [31:0] ram_mem [16];
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) ram_mem[i] <= seed_word(i);
            ram_rdata <= '0;
        end else begin
            if (ram_ren) ram_rdata <= ram_mem[ram_addr[5:2]];
            for (int b = 0; b < 4; b++)
                if (ram_wen[b])
                    ram_mem[ram_addr[5:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
    end

    // Reference model: owner 0=none 1=M0 2=M1, run = accepts this ownership.
    int          mo, mlast, mrun, mrv;
    logic [31:0] mrd;
    logic [31:0] mmem [16];

    int          e_who;
    logic        e_acc, e_ren;
    logic [3:0]  e_wen;
    always_comb begin
        e_who = 0;
        e_acc = 1'b0;
        if (mo != 0) begin
            e_who = mo - 1;
            e_acc = req[e_who];
        end
        e_ren = e_acc && !we[e_who];
        e_wen = (e_acc && we[e_who]) ? sel[e_who] : 4'b0000;
    end

    task automatic model_reset;
        mo = 0; mlast = 2; mrun = 0; mrv = 0; mrd = '0;
        for (int i = 0; i < 16; i++) mmem[i] = seed_word(i);
    endtask

    task automatic model_step;
        int w, nxt;
        mrv = 0;
        if (mo != 0 && req[mo-1]) begin
            w = mo - 1;
            if (we[w]) begin
                for (int b = 0; b < 4; b++)
                    if (sel[w][b])
                        mmem[addr[w][5:2]][8*b +: 8] = wdata[w][8*b +: 8];
            end else begin
                mrv = mo;
                mrd = mmem[addr[w][5:2]];
            end
            mrun = (mrun + 1 > MH) ? MH : mrun + 1;
        end
        nxt = mo;
        if (mo == 0) begin
            if (req[0] && req[1]) nxt = (mlast == 1) ? 2 : 1;
            else if (req[0])      nxt = 1;
            else if (req[1])      nxt = 2;
        end else if (!req[mo-1]) begin
            nxt = req[2-mo] ? 3 - mo : 0;
        end else if (req[2-mo] && mrun >= MH) begin
            nxt = 3 - mo;
        end
        if (nxt != mo) begin
            mrun = 0;
            if (nxt != 0) mlast = nxt;
        end
        mo = nxt;
    endtask

    task automatic tick;
        @(posedge clk);
        if (!rst) model_reset();
        else      model_step();
        #1;
    endtask

    task automatic idle_inputs;
        for (int m = 0; m < 2; m++) begin
            req[m] = 0; we[m] = 0; sel[m] = 4'hF;
            addr[m] = '0; wdata[m] = '0;
        end
    endtask

    task automatic do_reset;
        idle_inputs();
        rst = 0;
        model_reset();
        tick(); tick();
        rst = 1;
    endtask

    task automatic test_reset;
        idle_inputs();
        req[0] = 1; req[1] = 1;
        rst = 1; #1; rst = 0; model_reset(); #1;
        checks++;
        if (all_outs !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", all_outs);
        end
        tick(); tick();
        rst = 1; req[0] = 0; req[1] = 0;
        @(negedge clk);
        checks++;
        if ({m0_gnt, m1_gnt, busy} !== 3'b000) begin
            errors++;
            $display("FAIL idle_after_reset: got %b expected 000",
                     {m0_gnt, m1_gnt, busy});
        end
        tick();
    endtask

    task automatic test_single_read;
        do_reset();
        req[0] = 1; we[0] = 0; addr[0] = 32'h10;
        @(negedge clk);
        checks++;
        if (m0_gnt !== 1'b0) begin
            errors++; $display("FAIL sr_gnt_c1: got %b expected 0", m0_gnt);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({m0_gnt, m1_gnt, ram_ren, ram_wen} !== 7'b1010000) begin
            errors++;
            $display("FAIL sr_issue: got %b expected 1010000",
                     {m0_gnt, m1_gnt, ram_ren, ram_wen});
        end
        checks++;
        if (ram_addr !== 32'h10) begin
            errors++; $display("FAIL sr_addr: got %h expected 10", ram_addr);
        end
        tick();
        req[0] = 0;
        @(negedge clk);
        checks++;
        if ({m0_rvalid, m1_rvalid, m1_gnt} !== 3'b100 || m0_rdata !== mrd) begin
            errors++;
            $display("FAIL sr_return: got %b/%h expected 100/%h",
                     {m0_rvalid, m1_rvalid, m1_gnt}, m0_rdata, mrd);
        end
        tick();
        @(negedge clk);
        checks++;
        if (m0_rvalid !== 1'b0) begin
            errors++; $display("FAIL sr_one_shot: got %b expected 0", m0_rvalid);
        end
        tick();
    endtask

    task automatic test_tie;
        do_reset();
        req[0] = 1; addr[0] = 32'h4;
        req[1] = 1; addr[1] = 32'h8;
        @(negedge clk);
        tick();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({m0_gnt, m1_gnt} !== 2'b10) begin
                errors++;
                $display("FAIL tie_m0_first[%0d]: got %b expected 10",
                         k, {m0_gnt, m1_gnt});
            end
            tick();
        end
        req[0] = 0;
        @(negedge clk);
        checks++;
        if ({m0_gnt, m1_gnt, ram_ren} !== 3'b100) begin
            errors++;
            $display("FAIL tie_drop: got %b expected 100",
                     {m0_gnt, m1_gnt, ram_ren});
        end
        tick();
        @(negedge clk);
        checks++;
        if ({m0_gnt, m1_gnt, busy} !== 3'b011) begin
            errors++;
            $display("FAIL tie_handover: got %b expected 011",
                     {m0_gnt, m1_gnt, busy});
        end
        tick();
        req[1] = 0;
        tick(); tick();
    endtask

    task automatic test_rotation;
        logic [1:0] exp_g;
        do_reset();
        req[0] = 1; addr[0] = 32'h0C;
        req[1] = 1; addr[1] = 32'h30;
        @(negedge clk);
        tick();
        for (int k = 0; k < 6 * MH; k++) begin
            @(negedge clk);
            exp_g = (((k / MH) % 2) == 0) ? 2'b10 : 2'b01;
            checks++;
            if ({m0_gnt, m1_gnt} !== exp_g) begin
                errors++;
                $display("FAIL rot_gnt[%0d]: got %b expected %b",
                         k, {m0_gnt, m1_gnt}, exp_g);
            end
            checks++;
            if ({m0_rvalid, m1_rvalid} !== {mrv == 1, mrv == 2}) begin
                errors++;
                $display("FAIL rot_rvalid[%0d]: got %b expected %b",
                         k, {m0_rvalid, m1_rvalid}, {mrv == 1, mrv == 2});
            end
            tick();
        end
        req[0] = 0; req[1] = 0;
        tick(); tick();
    endtask

    task automatic test_write_read;
        do_reset();
        req[1] = 1; we[1] = 1; sel[1] = 4'b0011;
        addr[1] = 32'h20; wdata[1] = 32'hA5A5_1234;
        @(negedge clk);
        tick();
        @(negedge clk);
        checks++;
        if ({m1_gnt, ram_ren, ram_wen} !== 6'b100011 ||
            ram_addr !== 32'h20 || ram_wdata !== 32'hA5A5_1234) begin
            errors++;
            $display("FAIL wr_issue: got %b %h %h expected 100011 20 a5a51234",
                     {m1_gnt, ram_ren, ram_wen}, ram_addr, ram_wdata);
        end
        tick();
        req[1] = 0; we[1] = 0;
        req[0] = 1; we[0] = 0; addr[0] = 32'h20;
        @(negedge clk);
        tick();
        @(negedge clk);
        checks++;
        if ({m0_gnt, ram_ren} !== 2'b11 || ram_addr !== 32'h20) begin
            errors++;
            $display("FAIL wr_read_issue: got %b %h expected 11 20",
                     {m0_gnt, ram_ren}, ram_addr);
        end
        tick();
        req[0] = 0;
        @(negedge clk);
        checks++;
        if (m0_rvalid !== 1'b1 || m0_rdata[15:0] !== 16'h1234 ||
            m0_rdata !== mrd) begin
            errors++;
            $display("FAIL wr_read_data: got %b %h expected 1 %h",
                     m0_rvalid, m0_rdata, mrd);
        end
        tick();
    endtask

    task automatic test_hold_limit_read;
        do_reset();
        req[0] = 1; we[0] = 0; addr[0] = 32'h0;
        req[1] = 1; we[1] = 0; addr[1] = 32'h2C;
        @(negedge clk);
        tick();
        for (int k = 0; k < MH; k++) begin
            addr[0] = 32'(k * 4);
            @(negedge clk);
            tick();
        end
        @(negedge clk);
        checks++;
        if ({m1_gnt, m0_rvalid, m1_rvalid} !== 3'b110 ||
            m0_rdata !== seed_word(MH - 1)) begin
            errors++;
            $display("FAIL hold_read_return: got %b %h expected 110 %h",
                     {m1_gnt, m0_rvalid, m1_rvalid}, m0_rdata,
                     seed_word(MH - 1));
        end
        tick();
        req[0] = 0;
        @(negedge clk);
        checks++;
        if ({m0_rvalid, m1_rvalid} !== 2'b01 || m1_rdata !== mrd) begin
            errors++;
            $display("FAIL hold_m1_return: got %b %h expected 01 %h",
                     {m0_rvalid, m1_rvalid}, m1_rdata, mrd);
        end
        tick();
        req[1] = 0;
        tick(); tick();
    endtask

    task automatic test_reset_mid;
        do_reset();
        req[0] = 1; we[0] = 0; addr[0] = 32'h14;
        @(negedge clk);
        tick();
        @(negedge clk);
        checks++;
        if (ram_ren !== 1'b1) begin
            errors++; $display("FAIL rm_accept: got %b expected 1", ram_ren);
        end
        tick();
        rst = 0;
        model_reset();
        #1;
        checks++;
        if (all_outs !== '0) begin
            errors++;
            $display("FAIL rm_async_clear: got %h expected 0", all_outs);
        end
        @(negedge clk);
        checks++;
        if ({m0_rvalid, m1_rvalid} !== 2'b00) begin
            errors++;
            $display("FAIL rm_no_rvalid: got %b expected 00",
                     {m0_rvalid, m1_rvalid});
        end
        tick(); tick();
        rst = 1; req[0] = 0;
        @(negedge clk);
        checks++;
        if ({m0_gnt, m1_gnt, busy, m0_rvalid, m1_rvalid} !== 5'b00000) begin
            errors++;
            $display("FAIL rm_idle_after: got %b expected 00000",
                     {m0_gnt, m1_gnt, busy, m0_rvalid, m1_rvalid});
        end
        tick();
    endtask

    task automatic drive_random;
        for (int m = 0; m < 2; m++) begin
            if (req[m] && mo != m + 1) begin
                if ($urandom_range(0, 7) == 0) req[m] = 0;
            end else begin
                req[m]   = ($urandom_range(0, 3) != 0);
                we[m]    = 1'($urandom_range(0, 1));
                sel[m]   = 4'($urandom);
                addr[m]  = $urandom & 32'h0000_FF3C;
                wdata[m] = $urandom;
            end
        end
    endtask

    task automatic test_random;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            drive_random();
            @(negedge clk);
            checks++;
            if ({m0_gnt, m1_gnt, busy} !== {mo == 1, mo == 2, mo != 0}) begin
                errors++;
                $display("FAIL rnd_gnt[%0d]: got %b expected %b", c,
                         {m0_gnt, m1_gnt, busy}, {mo == 1, mo == 2, mo != 0});
            end
            checks++;
            if ({ram_ren, ram_wen} !== {e_ren, e_wen}) begin
                errors++;
                $display("FAIL rnd_issue[%0d]: got %b expected %b", c,
                         {ram_ren, ram_wen}, {e_ren, e_wen});
            end
            if (e_acc) begin
                checks++;
                if (ram_addr !== addr[e_who] ||
                    (we[e_who] && ram_wdata !== wdata[e_who])) begin
                    errors++;
                    $display("FAIL rnd_addr[%0d]: got %h/%h expected %h/%h",
                             c, ram_addr, ram_wdata, addr[e_who],
                             wdata[e_who]);
                end
            end
            checks++;
            if ({m0_rvalid, m1_rvalid} !== {mrv == 1, mrv == 2}) begin
                errors++;
                $display("FAIL rnd_rvalid[%0d]: got %b expected %b", c,
                         {m0_rvalid, m1_rvalid}, {mrv == 1, mrv == 2});
            end
            if (mrv != 0) begin
                checks++;
                if ((mrv == 1 ? m0_rdata : m1_rdata) !== mrd) begin
                    errors++;
                    $display("FAIL rnd_rdata[%0d]: got %h expected %h", c,
                             (mrv == 1 ? m0_rdata : m1_rdata), mrd);
                end
            end
            tick();
        end
        idle_inputs();
        tick(); tick();
    endtask

    initial begin
        idle_inputs();
        model_reset();
        test_reset();
        test_single_read();
        test_tie();
        test_rotation();
        test_write_read();
        test_hold_limit_read();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-master arbiter that shares the single data RAM port between the core load/store unit (M0) and a debug/DMA master (M1), such as the UART debug loader.
- Round-robin ownership with a bounded hold time, registered grants and one-cycle synchronous read return routed back to the issuing master.
- Sits between the masters and the ram instance in the SoC top level.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MAX_HOLD, 8, max consecutive accepted cycles per ownership while the other master waits; ≥1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- m0_req  in  1  M0 access request
- m0_we  in  1  M0 1=write, 0=read
- m0_sel  in  4  M0 byte enables for writes
- m0_addr  in  AW  M0 address
- m0_wdata  in  DW  M0 write data
- m0_gnt  out  1  M0 owns port; access accepted when m0_req&&m0_gnt
- m0_rvalid  out  1  M0 read data valid
- m0_rdata  out  DW  M0 read data
- m1_req/m1_we/m1_sel/m1_addr/m1_wdata/m1_gnt/m1_rvalid/m1_rdata  as for M0, for master 1
- ram_ren  out  1  RAM read enable
- ram_wen  out  4  RAM byte write enables
- ram_addr  out  AW  RAM address (shared by read and write)
- ram_wdata  out  DW  RAM write data
- ram_rdata  in  DW  RAM read data, valid the cycle after ram_ren
- busy  out  1  high in OWN0/OWN1

Behaviour:
- Reset (rst=0, async):
  - State IDLE; gnt0/gnt1=0; rvalid0/rvalid1=0; rdata=0; hold_cnt=0.
  - last_owner=1, so M0 wins the first tie.
  - All ram_* outputs 0.
- FSM states: IDLE, OWN0, OWN1. m0_gnt=(state==OWN0), m1_gnt=(state==OWN1); both are registered and never high together.
- From IDLE:
  - Exactly one req → OWNx at the next edge.
  - Both req → owner is the master != last_owner.
  - None → stay IDLE.
- From OWNx:
  - req_x=0, other req=1 → OWN_other.
  - req_x=0, other req=0 → IDLE.
  - req_x=1, other req=1, hold_cnt==MAX_HOLD-1 → OWN_other (forced rotation).
  - Otherwise stay OWNx.
- Switches between owners are direct, with no idle cycle. last_owner updates on every switch to OWNx.
- hold_cnt:
  - Increments on each accepted cycle in OWNx.
  - Clears on any state change.
  - Saturates at MAX_HOLD-1 when the other master is not requesting; no wrap.
- Access issue is combinational in the accept cycle (req&&gnt of the owner):
  - ram_addr = owner addr.
  - Write: ram_wen = owner sel, ram_ren = 0.
  - Read: ram_ren = 1, ram_wen = 0.
  - No accept → ram_ren = 0, ram_wen = 0, ram_addr/ram_wdata hold owner values (don't care).
- Read return:
  - rd_id is registered at the accept.
  - The cycle after a read accept: rvalid_{rd_id}=1 for exactly one cycle and rdata_{rd_id}=ram_rdata, registered-through (a combinational mux of ram_rdata with a registered rvalid).
  - Write latency is 0: complete at the accept edge; no response.
- Back-to-back reads by one master: one per cycle, rvalid each following cycle.
- A read accepted in the last ownership cycle still returns to its issuer after the grant has moved.
- Masters hold addr/we/sel/wdata stable while req=1 and gnt=0. Dropping req before gnt is legal and nothing is issued.
- Same-cycle read (M1) after write (M0) to the same address: RAM ordering; the write lands first.
- Reset asserted mid-access: in-flight read is discarded and no rvalid follows.

Test Plan:
- Reset, then m0_req read addr 0x10 at cycle 1 → m0_gnt=1 cycle 2, ram_ren=1 ram_addr=0x10 cycle 2, m0_rvalid=1 with RAM word cycle 3; m1_gnt stays 0.
- m0_req and m1_req raised in the same cycle from IDLE after reset → M0 granted first; when M0 drops req, M1 granted on the very next cycle (no IDLE gap).
- Both hold req continuously with MAX_HOLD=8 → grants alternate in blocks of 8 accepted cycles: OWN0×8, OWN1×8, OWN0×8…; m0_gnt&&m1_gnt never 1.
- M1 write sel=4'b0011 data 0xA5A5_1234 to 0x20, then M0 read 0x20 → ram_wen=4'b0011 on the M1 accept; M0 rdata low half 0x1234.
- M0 read accepted at hold limit, grant moves to M1 next cycle → m0_rvalid=1 that cycle with correct data; m1_rvalid=0.
- rst pulled low the cycle after a read accept → no rvalid either master; all outputs 0 immediately (async); state IDLE after release.
